// File: rtl/cov_feed_skew_if.sv
// Snapshot handshake into the feeder and skewed I/Q stream out to
// the covariance array.
interface cov_feed_skew_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH = 4
);
  logic in_valid;
  logic in_ready;
  logic [NUM_CH*DATA_WIDTH-1:0] in_q;
  logic [NUM_CH*DATA_WIDTH-1:0] in_i;
  logic [NUM_CH*DATA_WIDTH-1:0] out_q;
  logic [NUM_CH*DATA_WIDTH-1:0] out_i;
  logic [NUM_CH-1:0] out_finish;
  logic block_done;
  logic busy;

  modport master (
    output in_valid, in_q, in_i,
    input  in_ready, out_q, out_i,
    input  out_finish, block_done, busy
  );

  modport slave (
    input  in_valid, in_q, in_i,
    output in_ready, out_q, out_i,
    output out_finish, block_done, busy
  );
endinterface

// File: rtl/cov_feed_skew.sv
// Ping-pong block buffer feeding the covariance array with
// per-channel skew (channel k delayed by k cycles).
module cov_feed_skew #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH = 4,
  parameter int SAMPLES_BITS = 4
) (
  input logic clk,
  input logic rst_n,
  cov_feed_skew_if.slave bus
);
  localparam int L = 1 << SAMPLES_BITS;
  localparam int CW = NUM_CH * DATA_WIDTH;
  localparam int SW = 2 * DATA_WIDTH + 2;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state_q, state_d;
  logic [1:0] full_q, full_d;
  logic wr_bank_q, wr_bank_d;
  logic rd_bank_q, rd_bank_d;
  logic [SAMPLES_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [SAMPLES_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [2*CW-1:0] mem [2*L];
  logic [2*CW-1:0] rd_word;
  logic accept, rd_en, rd_last;
  logic [SW-1:0] s0_q [NUM_CH];
  logic [SW-1:0] s0_d [NUM_CH];
  logic [SW-1:0] tap [NUM_CH];
  logic [NUM_CH-1:0] ch_busy;
  logic [CW-1:0] oq, oi;
  logic [NUM_CH-1:0] ofin;

  assign bus.in_ready = !full_q[wr_bank_q];
  assign accept = bus.in_valid && bus.in_ready;
  assign rd_word = mem[{rd_bank_q, rd_addr_q}];

  always_ff @(posedge clk) begin
    if (accept) mem[{wr_bank_q, wr_addr_q}] <= {bus.in_q, bus.in_i};
  end

  always_comb begin
    state_d = state_q;
    full_d = full_q;
    wr_bank_d = wr_bank_q;
    wr_addr_d = wr_addr_q;
    rd_bank_d = rd_bank_q;
    rd_addr_d = rd_addr_q;
    rd_en = 1'b0;
    rd_last = 1'b0;
    if (accept) begin
      wr_addr_d = wr_addr_q + 1'b1;
      if (&wr_addr_q) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d = !wr_bank_q;
      end
    end
    unique case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = STREAM;
          rd_addr_d = '0;
        end
      end
      STREAM: begin
        rd_en = 1'b1;
        rd_last = &rd_addr_q;
        rd_addr_d = rd_addr_q + 1'b1;
        // a bank filled on this same edge still counts, so no gap
        if (rd_last) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d = !rd_bank_q;
          state_d = full_d[!rd_bank_q] ? STREAM : IDLE;
        end
      end
    endcase
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      s0_d[k] = {rd_en, rd_last,
                 rd_word[CW + k*DATA_WIDTH +: DATA_WIDTH],
                 rd_word[k*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      full_q <= '0;
      wr_bank_q <= 1'b0;
      wr_addr_q <= '0;
      rd_bank_q <= 1'b0;
      rd_addr_q <= '0;
      for (int k = 0; k < NUM_CH; k++) s0_q[k] <= '0;
    end else begin
      state_q <= state_d;
      full_q <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_addr_q <= wr_addr_d;
      rd_bank_q <= rd_bank_d;
      rd_addr_q <= rd_addr_d;
      for (int k = 0; k < NUM_CH; k++) s0_q[k] <= s0_d[k];
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    if (k == 0) begin : g_direct
      assign tap[k] = s0_q[k];
      assign ch_busy[k] = s0_q[k][SW-1];
    end else begin : g_dly
      logic [SW-1:0] dly_q [k];
      logic [SW-1:0] dly_d [k];
      logic [k-1:0] v;

      always_comb begin
        dly_d[0] = s0_q[k];
        for (int d = 1; d < k; d++) dly_d[d] = dly_q[d-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < k; d++) dly_q[d] <= '0;
        end else begin
          for (int d = 0; d < k; d++) dly_q[d] <= dly_d[d];
        end
      end

      always_comb begin
        for (int d = 0; d < k; d++) v[d] = dly_q[d][SW-1];
      end

      assign tap[k] = dly_q[k-1];
      assign ch_busy[k] = s0_q[k][SW-1] | (|v);
    end
  end

  always_comb begin
    oq = '0;
    oi = '0;
    ofin = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (tap[k][SW-1]) begin
        oq[k*DATA_WIDTH +: DATA_WIDTH] =
          tap[k][2*DATA_WIDTH-1:DATA_WIDTH];
        oi[k*DATA_WIDTH +: DATA_WIDTH] =
          tap[k][DATA_WIDTH-1:0];
        ofin[k] = tap[k][SW-2];
      end
    end
  end

  assign bus.out_q = oq;
  assign bus.out_i = oi;
  assign bus.out_finish = ofin;
  assign bus.block_done = ofin[NUM_CH-1];
  assign bus.busy = (state_q == STREAM) || (|ch_busy);
endmodule

// File: tb/tb_cov_feed_skew.sv
// Vector table of block scenarios feeding a scoreboard that holds
// each channel's expected output per clock edge.
module tb_cov_feed_skew;
  localparam int DW = 16;
  localparam int NCH = 4;
  localparam int SB = 4;
  localparam int L = 1 << SB;
  localparam int D = 1024;

  typedef struct {
    int e;
    logic [DW-1:0] q;
    logic [DW-1:0] i;
    logic f;
  } item_t;

  typedef struct {
    int pat;
    int nsnap;
    int vmode;
    int stalls;
    int blocks;
    int pe;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  item_t exq [NCH][D];
  int hd [NCH];
  int tl [NCH];
  int iv_lo[$];
  int iv_hi[$];
  logic [DW-1:0] bq [L][NCH];
  logic [DW-1:0] bi [L][NCH];
  int blk_cnt = 0;
  int last_start = -1000;
  int fin_cnt [NCH];
  longint pe_acc = 0;
  longint pe_res = 0;

  cov_feed_skew_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();

  cov_feed_skew #(
    .DATA_WIDTH(DW),
    .NUM_CH(NCH),
    .SAMPLES_BITS(SB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // output monitor: after edge n, each channel shows its item for n or 0
  logic [DW-1:0] m_q, m_i, e_q, e_i;
  logic m_f, e_f, e_bd, e_busy;
  int pa, pb;
  always @(negedge clk) begin
    e_bd = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      m_q = bus.out_q[k*DW +: DW];
      m_i = bus.out_i[k*DW +: DW];
      m_f = bus.out_finish[k];
      e_q = '0;
      e_i = '0;
      e_f = 1'b0;
      if (hd[k] != tl[k] && exq[k][hd[k] % D].e == cyc) begin
        e_q = exq[k][hd[k] % D].q;
        e_i = exq[k][hd[k] % D].i;
        e_f = exq[k][hd[k] % D].f;
        hd[k]++;
      end
      chk($sformatf("ch%0d_out", k), 64'({m_q, m_i, m_f}),
          64'({e_q, e_i, e_f}));
      if (k == NCH - 1) e_bd = e_f;
      if (m_f) fin_cnt[k]++;
    end
    chk("block_done", 64'(bus.block_done), 64'(e_bd));
    e_busy = 1'b0;
    foreach (iv_lo[x])
      if (cyc >= iv_lo[x] && cyc <= iv_hi[x]) e_busy = 1'b1;
    chk("busy", 64'(bus.busy), 64'(e_busy));
    pa = int'($signed(bus.out_q[DW-1:0]));
    pb = int'($signed(bus.out_i[DW-1:0]));
    if (bus.out_finish[0]) begin
      pe_res = (pe_acc + longint'(pa*pa + pb*pb)) >>> 4;
      pe_acc = 0;
    end else begin
      pe_acc = pe_acc + longint'(pa*pa + pb*pb);
    end
  end

  task automatic record(input int e, input logic [NCH*DW-1:0] q,
                        input logic [NCH*DW-1:0] i);
    int s;
    for (int k = 0; k < NCH; k++) begin
      bq[blk_cnt][k] = q[k*DW +: DW];
      bi[blk_cnt][k] = i[k*DW +: DW];
    end
    blk_cnt++;
    if (blk_cnt == L) begin
      s = (e <= last_start + L - 1) ? last_start + L : e + 2;
      for (int k = 0; k < NCH; k++) begin
        for (int j = 0; j < L; j++) begin
          exq[k][tl[k] % D] =
            '{s + j + k, bq[j][k], bi[j][k], 1'(j == L - 1)};
          tl[k]++;
        end
      end
      iv_lo.push_back(s - 1);
      iv_hi.push_back(s + L + NCH - 2);
      last_start = s;
      blk_cnt = 0;
    end
  endtask

  task automatic gen(input int pat, input int idx,
                     output logic [NCH*DW-1:0] q,
                     output logic [NCH*DW-1:0] i);
    logic [DW-1:0] a;
    for (int k = 0; k < NCH; k++) begin
      case (pat)
        0: begin
          a = DW'(100 * k + idx);
          q[k*DW +: DW] = a;
          i[k*DW +: DW] = -a;
        end
        1: begin
          a = ((idx + k) % 2 == 1) ? 16'h7FFF : 16'h8000;
          q[k*DW +: DW] = a;
          i[k*DW +: DW] = ~a;
        end
        2: begin
          q[k*DW +: DW] = 16'd4;
          i[k*DW +: DW] = 16'd4;
        end
        default: begin
          q[k*DW +: DW] = DW'($urandom);
          i[k*DW +: DW] = DW'($urandom);
        end
      endcase
    end
  endtask

  task automatic send(input logic [NCH*DW-1:0] q,
                      input logic [NCH*DW-1:0] i, output int stl);
    int w;
    bit done;
    stl = 0;
    w = 0;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_q = q;
    bus.in_i = i;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        record(cyc + 1, q, i);
        done = 1'b1;
      end else begin
        stl++;
        w++;
        if (w > 100) begin
          total++;
          bad++;
          $display("FAIL in_ready_timeout cyc=%0d", cyc);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drive(input int pat, input int n, input int vmode,
                       output int stl);
    logic [NCH*DW-1:0] q, i;
    int s1;
    stl = 0;
    @(posedge clk);
    #1;
    for (int x = 0; x < n; x++) begin
      gen(pat, x, q, i);
      send(q, i, s1);
      stl += s1;
      if (vmode == 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int w;
    bit empty;
    w = 0;
    do begin
      @(posedge clk);
      #2;
      empty = 1'b1;
      for (int k = 0; k < NCH; k++) if (hd[k] != tl[k]) empty = 1'b0;
      w++;
    end while (!empty && w < 300);
    if (!empty) begin
      total++;
      bad++;
      $display("FAIL drain_timeout cyc=%0d", cyc);
    end
    repeat (NCH + 2) @(posedge clk);
    #2;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int stl;
    for (int k = 0; k < NCH; k++) fin_cnt[k] = 0;
    drive(v.pat, v.nsnap, v.vmode, stl);
    drain();
    chk($sformatf("v%0d_stalls", id), 64'(stl), 64'(v.stalls));
    for (int k = 0; k < NCH; k++)
      chk($sformatf("v%0d_fin%0d", id, k), 64'(fin_cnt[k]),
          64'(v.blocks));
    chk($sformatf("v%0d_idle_busy", id), 64'(bus.busy), 64'd0);
    if (v.pe >= 0)
      chk($sformatf("v%0d_pe", id), 64'(pe_res), 64'(v.pe));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_q"}, bus.out_q, 64'd0);
    chk({nm, "_i"}, bus.out_i, 64'd0);
    chk({nm, "_fin"}, 64'(bus.out_finish), 64'd0);
    chk({nm, "_bd"}, 64'(bus.block_done), 64'd0);
    chk({nm, "_busy"}, 64'(bus.busy), 64'd0);
    chk({nm, "_rdy"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    vec_t vt [5];
    int stl;
    vt[0] = '{0, 16, 0, 0, 1, -1};
    vt[1] = '{0, 48, 0, 1, 3, -1};
    vt[2] = '{1, 16, 1, 0, 1, -1};
    vt[3] = '{2, 16, 0, 0, 1, 32};
    vt[4] = '{3, 32, 1, 0, 2, -1};

    bus.in_valid = 1'b0;
    bus.in_q = '0;
    bus.in_i = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_zero("reset");
    #19 rst_n = 1'b1;

    for (int v = 0; v < 5; v++) run_vec(v, vt[v]);

    // reset while the second of two blocks is mid-stream
    for (int k = 0; k < NCH; k++) fin_cnt[k] = 0;
    drive(0, 32, 0, stl);
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    for (int k = 0; k < NCH; k++) hd[k] = tl[k];
    iv_lo.delete();
    iv_hi.delete();
    blk_cnt = 0;
    last_start = -1000;
    pe_acc = 0;
    #1 chk_zero("midrst");
    chk("midrst_fin_before", 64'(fin_cnt[NCH-1]), 64'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    run_vec(5, vt[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
